conv_stream: RTL and testbench

Streaming, parametrised 3x3 convolution engine for the image coprocessor. It accepts a raster-order pixel stream of CH packed channels, each PW bits wide, and builds the 3x3 window internally with two line buffers. Each window is convolved with a selectable kernel: edge, blur, sharpen, nop, or a custom signed kernel. It emits the (IMG_W-2)x(IMG_H-2) interior result stream with valid/ready handshakes on both sides.

---
 rtl/conv_stream.sv | 187 ++++++++++++++++++
 tb/tb_conv_stream.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_stream.sv
// Streaming 3x3 convolution over a raster pixel stream; two line buffers build the
// window and a single output register carries the clamped interior result.
module conv_stream #(
  parameter int unsigned PW    = 4,
  parameter int unsigned CH    = 3,
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          func,
  input  logic [35:0]         kern_coef,
  input  logic [2:0]          kern_shift,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sof,
  input  logic [CH*PW-1:0]    in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH*PW-1:0]    out_data,
  output logic                out_last,
  output logic                busy
);

  localparam int unsigned DW  = CH * PW;
  localparam int unsigned ACC = PW + 8;
  localparam int unsigned CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic signed [ACC-1:0] PMAX = ACC'((1 << PW) - 1);

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic [2:0]    mode_q, mode_d;
  logic [35:0]   coef_q, coef_d;
  logic [2:0]    shift_q, shift_d;
  logic          busy_q, busy_d;
  logic          ov_q, ov_d;
  logic [DW-1:0] od_q, od_d;
  logic          ol_q, ol_d;

  logic          accept, frame_end, win_ok;
  logic [DW-1:0] lb1 [IMG_W];
  logic [DW-1:0] lb2 [IMG_W];
  logic [DW-1:0] lb1_rd, lb2_rd;
  logic [DW-1:0] top_q [2];
  logic [DW-1:0] mid_q [2];
  logic [DW-1:0] bot_q [2];
  logic [DW-1:0] win [9];
  logic [9*PW-1:0] win_ch;
  logic [DW-1:0] result;

  // One channel of the 3x3 convolution, clamped to the pixel range.
  function automatic logic [PW-1:0] conv_ch(input logic [2:0] mode, input logic [35:0] coef,
                                            input logic [2:0] sh, input logic [9*PW-1:0] w);
    logic signed [ACC-1:0] p [9];
    logic signed [ACC-1:0] acc;
    logic signed [ACC-1:0] c;
    logic [PW-1:0]         res;
    for (int i = 0; i < 9; i++) p[i] = signed'(ACC'(w[i*PW +: PW]));
    acc = '0;
    c   = '0;
    case (mode)
      3'd0: acc = (p[4] <<< 3) - (p[0] + p[1] + p[2] + p[3] + p[5] + p[6] + p[7] + p[8]);
      3'd1: acc = (p[0] + p[2] + p[6] + p[8] + ((p[1] + p[3] + p[5] + p[7]) <<< 1)
                   + (p[4] <<< 2)) >>> 4;
      3'd2: acc = (p[4] <<< 2) + p[4] - p[1] - p[3] - p[5] - p[7];
      3'd4: begin
        for (int i = 0; i < 9; i++) begin
          c   = ACC'(signed'(coef[i*4 +: 4]));
          acc = acc + c * p[i];
        end
        acc = acc >>> sh;
      end
      default: acc = p[4];
    endcase
    if (acc < 0)         res = '0;
    else if (acc > PMAX) res = '1;
    else                 res = acc[PW-1:0];
    return res;
  endfunction

  assign in_ready  = !ov_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign cur_col   = in_sof ? '0 : col_q;
  assign cur_row   = in_sof ? '0 : row_q;
  assign frame_end = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
  assign win_ok    = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
  assign lb1_rd    = lb1[cur_col];
  assign lb2_rd    = lb2[cur_col];

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_last  = ol_q;
  assign busy      = busy_q;

  // Window rows r-2, r-1, r by columns c-2, c-1, c (incoming pixel bottom-right).
  always_comb begin
    win[0] = top_q[0]; win[1] = top_q[1]; win[2] = lb2_rd;
    win[3] = mid_q[0]; win[4] = mid_q[1]; win[5] = lb1_rd;
    win[6] = bot_q[0]; win[7] = bot_q[1]; win[8] = in_data;
  end

  always_comb begin
    result = '0;
    win_ch = '0;
    for (int k = 0; k < CH; k++) begin
      for (int i = 0; i < 9; i++) win_ch[i*PW +: PW] = win[i][k*PW +: PW];
      result[k*PW +: PW] = conv_ch(mode_q, coef_q, shift_q, win_ch);
    end
  end

  // Counters, mode latch and output register next state.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    mode_d  = mode_q;
    coef_d  = coef_q;
    shift_d = shift_q;
    busy_d  = busy_q;
    ov_d    = ov_q;
    od_d    = od_q;
    ol_d    = ol_q;
    if (accept) begin
      busy_d = !frame_end;
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
      if ((cur_row == '0) && (cur_col == '0)) begin
        mode_d  = func;
        coef_d  = kern_coef;
        shift_d = kern_shift;
      end
    end
    if (accept && win_ok) begin
      ov_d = 1'b1;
      od_d = result;
      ol_d = frame_end;
    end else if (out_ready) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      mode_q  <= 3'd3;
      coef_q  <= '0;
      shift_q <= '0;
      busy_q  <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      ol_q    <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      mode_q  <= mode_d;
      coef_q  <= coef_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      ol_q    <= ol_d;
    end
  end

  // Line buffers and column shift registers hold pixel data only; never reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[cur_col] <= in_data;
      lb2[cur_col] <= lb1_rd;
      top_q[0]     <= top_q[1];
      top_q[1]     <= lb2_rd;
      mid_q[0]     <= mid_q[1];
      mid_q[1]     <= lb1_rd;
      bot_q[0]     <= bot_q[1];
      bot_q[1]     <= in_data;
    end
  end

endmodule

// File: tb/tb_conv_stream.sv
// Randomised and directed bench for conv_stream against a frame-level reference model.
module tb_conv_stream;

  localparam int PW    = 4;
  localparam int CH    = 2;
  localparam int IMG_W = 4;
  localparam int IMG_H = 4;
  localparam int DW    = PW * CH;
  localparam int NPIX  = IMG_W * IMG_H;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    func;
  logic [35:0]   kern_coef;
  logic [2:0]    kern_shift;
  logic          in_valid;
  logic          in_ready;
  logic          in_sof;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;

  always #5 clk = ~clk;

  conv_stream #(.PW(PW), .CH(CH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .rst(rst), .func(func), .kern_coef(kern_coef), .kern_shift(kern_shift),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: image of the current frame plus the latched kernel.
  logic [DW-1:0] img [IMG_H][IMG_W];
  logic [DW-1:0] frame_px [NPIX];
  int            mr, mc;
  logic [2:0]    m_func;
  logic [35:0]   m_coef;
  logic [2:0]    m_shift;
  int            exp_q [$];
  bit            lat_pending;
  bit            busy_exp;
  bit            rand_bp;

  function automatic int ref_pix(input int r, input int c);
    int w [9];
    int sh, sum, v, res;
    logic [DW-1:0] px;
    sh = 0;
    case (m_func)
      3'd0: for (int k = 0; k < 9; k++) w[k] = (k == 4) ? 8 : -1;
      3'd1: begin w = '{1, 2, 1, 2, 4, 2, 1, 2, 1}; sh = 4; end
      3'd2: w = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
      3'd4: begin
        for (int k = 0; k < 9; k++) w[k] = int'($signed(m_coef[k*4 +: 4]));
        sh = int'(m_shift);
      end
      default: for (int k = 0; k < 9; k++) w[k] = (k == 4) ? 1 : 0;
    endcase
    res = 0;
    for (int ch = 0; ch < CH; ch++) begin
      sum = 0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          px  = img[r-2+i][c-2+j];
          sum = sum + w[i*3+j] * int'(px[ch*PW +: PW]);
        end
      v = sum >>> sh;
      if (v < 0) v = 0;
      else if (v > (1 << PW) - 1) v = (1 << PW) - 1;
      res = res | (v << (ch * PW));
    end
    return res;
  endfunction

  task automatic model_reset();
    mr = 0; mc = 0; m_func = 3'd3; m_coef = '0; m_shift = '0;
    busy_exp = 1'b0; lat_pending = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_accept(input logic [DW-1:0] px, input logic sof);
    bit last;
    if (sof) begin mr = 0; mc = 0; end
    if (mr == 0 && mc == 0) begin m_func = func; m_coef = kern_coef; m_shift = kern_shift; end
    img[mr][mc] = px;
    last = (mr == IMG_H - 1) && (mc == IMG_W - 1);
    if (mr >= 2 && mc >= 2) begin
      exp_q.push_back(ref_pix(mr, mc) | (last ? (1 << 16) : 0));
      lat_pending = 1'b1;
    end
    busy_exp = !last;
    if (mc == IMG_W - 1) begin
      mc = 0;
      mr = (mr == IMG_H - 1) ? 0 : mr + 1;
    end else begin
      mc++;
    end
  endtask

  // Present one pixel until accepted; inputs change 1 time unit after the rising edge.
  task automatic send(input logic [DW-1:0] px, input logic sof);
    bit ok;
    in_data = px; in_sof = sof; in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 1000 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    model_accept(px, sof);
    in_valid = 1'b0; in_sof = 1'b0;
    check("busy", int'(busy), int'(busy_exp));
  endtask

  task automatic send_frame(input bit sof_first, input bit scramble, input bit gaps);
    for (int i = 0; i < NPIX; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      send(frame_px[i], sof_first && i == 0);
      if (scramble) begin
        func = 3'($urandom); kern_shift = 3'($urandom);
        kern_coef = {4'($urandom), 32'($urandom)};
      end
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) begin @(posedge clk); #1; end
    check("drain", exp_q.size(), 0);
  endtask

  // Channel 0 carries the directed value; upper channels carry random data.
  task automatic fill(input int v);
    for (int i = 0; i < NPIX; i++)
      frame_px[i] = (DW'($urandom) & ~DW'((1 << PW) - 1)) | DW'(v);
  endtask

  // Output monitor: a handshake seen at the falling edge completes on the next rising edge.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (lat_pending) begin
          check("latency_valid", int'(out_valid), 1);
          lat_pending = 1'b0;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check("spurious_out", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("out_data", int'(out_data), e & ((1 << DW) - 1));
            check("out_last", int'(out_last), (e >> 16) & 1);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int e;
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; out_ready = 1'b1;
    func = 3'd3; kern_coef = '0; kern_shift = '0; rand_bp = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;

    // nop on a ramp: interior 5,6,9,10, last on the final one
    func = 3'd3;
    for (int i = 0; i < NPIX; i++) frame_px[i] = DW'(i) | (DW'(15 - i) << PW);
    send_frame(1'b1, 1'b0, 1'b0);
    drain();
    check("busy_after_frame", int'(busy), 0);

    // edge: flat field, then an isolated bright centre
    func = 3'd0; fill(7); send_frame(1'b0, 1'b0, 1'b0); drain();
    fill(0); frame_px[5][PW-1:0] = PW'(15); send_frame(1'b0, 1'b0, 1'b0); drain();

    // blur and sharpen
    func = 3'd1; fill(15); send_frame(1'b0, 1'b0, 1'b0); drain();
    func = 3'd2; fill(7);  send_frame(1'b0, 1'b0, 1'b0); drain();
    fill(0);
    frame_px[5][PW-1:0] = PW'(2);
    frame_px[1][PW-1:0] = PW'(15); frame_px[4][PW-1:0] = PW'(15);
    frame_px[6][PW-1:0] = PW'(15); frame_px[9][PW-1:0] = PW'(15);
    send_frame(1'b0, 1'b0, 1'b0); drain();

    // custom kernels, then kernel inputs scrambled after the first pixel
    func = 3'd4; kern_coef = {9{4'hF}}; kern_shift = 3'd0; fill(3);
    send_frame(1'b0, 1'b0, 1'b0); drain();
    func = 3'd4; kern_coef = {9{4'h1}}; kern_shift = 3'd3; fill(8);
    send_frame(1'b0, 1'b0, 1'b0); drain();
    func = 3'd1;
    for (int i = 0; i < NPIX; i++) frame_px[i] = DW'($urandom);
    send_frame(1'b0, 1'b1, 1'b0); drain();

    // backpressure: stall the first output for 5 cycles
    func = 3'd3;
    for (int i = 0; i < NPIX; i++) frame_px[i] = DW'(i) | (DW'($urandom) << PW);
    for (int i = 0; i <= 10; i++) send(frame_px[i], 1'b0);
    out_ready = 1'b0;
    check("bp_pending", exp_q.size(), 1);
    e = (exp_q.size() != 0) ? exp_q[0] : -1;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_out_data", int'(out_data), e & ((1 << DW) - 1));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int i = 11; i < NPIX; i++) send(frame_px[i], 1'b0);
    drain();

    // reset after 6 pixels, then a full frame without sof
    func = 3'd2;
    for (int i = 0; i < 6; i++) send(DW'($urandom), 1'b0);
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    model_reset();
    check("mrst_out_valid", int'(out_valid), 0);
    check("mrst_busy", int'(busy), 0);
    for (int i = 0; i < NPIX; i++) frame_px[i] = DW'($urandom);
    send_frame(1'b0, 1'b0, 1'b0); drain();

    // reset while an output is stalled
    for (int i = 0; i <= 10; i++) send(DW'($urandom), 1'b0);
    out_ready = 1'b0;
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    model_reset();
    check("mrst2_out_valid", int'(out_valid), 0);
    check("mrst2_in_ready", int'(in_ready), 1);
    out_ready = 1'b1;

    // sof mid-frame restarts at (0,0)
    for (int i = 0; i < 5; i++) send(DW'($urandom), 1'b0);
    func = 3'd4; kern_coef = {4'($urandom), 32'($urandom)}; kern_shift = 3'($urandom);
    for (int i = 0; i < NPIX; i++) frame_px[i] = DW'($urandom);
    send_frame(1'b1, 1'b0, 1'b0); drain();

    // random frames with random backpressure, gaps, sof and kernel changes
    rand_bp = 1'b1;
    for (int f = 0; f < 20; f++) begin
      func = 3'($urandom); kern_shift = 3'($urandom);
      kern_coef = {4'($urandom), 32'($urandom)};
      for (int i = 0; i < NPIX; i++) frame_px[i] = DW'($urandom);
      send_frame(1'($urandom), 1'($urandom), 1'b1);
    end
    drain();
    rand_bp = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (3) @(posedge clk);
    check("final_idle_valid", int'(out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
